// File: rtl/eq_compare_arbiter.sv
// eq_compare_arbiter
//
// Shares one WIDTH-bit equality comparator among NUM_REQ requesters.
// Requests are granted round-robin; both sides use valid/ready handshakes.
// Each accepted request produces one response carrying the requester ID and
// the flag set Equal, Z = !Equal, N = 0. A wrapping 16-bit counter tracks
// completed response handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req_valid  per-requester request valid                [NUM_REQ]
//   req_ready  per-requester accept, at most one bit high  [NUM_REQ]
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing as req_a
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     requester index of the current response     [IDW]
//   rsp_equal  1 when A == B
//   rsp_z      !rsp_equal
//   rsp_n      always 0
//   busy       high while a compare is in flight (CMP/RESP)
//   cmp_count  completed response handshakes, wraps        [16]

module eq_compare_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_equal,
    output logic                     rsp_z,
    output logic                     rsp_n,
    output logic                     busy,
    output logic [15:0]              cmp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // One extra bit so ptr + offset never overflows before the wrap subtract.
    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_equal_q, rsp_equal_d;
    logic             rsp_z_q, rsp_z_d;
    logic [15:0]      cmp_count_q, cmp_count_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW:0]     scan;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [NUM_REQ-1:0] ready_c;

    // Round-robin search: first valid index at or after ptr, wrapping modulo
    // NUM_REQ (works for non-power-of-two requester counts).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[scan[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IDW-1:0];
            end
        end
    end

    // Only the granted requester's operands reach the capture registers, so
    // unknown data on other lanes cannot leak into the result.
    assign sel_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[gnt_idx*WIDTH +: WIDTH];

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_id_d    = rsp_id_q;
        rsp_equal_d = rsp_equal_q;
        rsp_z_d     = rsp_z_q;
        cmp_count_d = cmp_count_q;
        ready_c     = '0;

        case (state_q)
            IDLE: begin
                // ready is raised only for a valid requester, so a grant is
                // always a completed transfer on this edge.
                if (gnt_found) begin
                    ready_c[gnt_idx] = 1'b1;
                    gnt_d            = gnt_idx;
                    a_d              = sel_a;
                    b_d              = sel_b;
                    state_d          = CMP;
                end
            end
            CMP: begin
                rsp_equal_d = (a_q == b_q);
                rsp_z_d     = !(a_q == b_q);
                rsp_id_d    = gnt_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    ptr_d       = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
                    cmp_count_d = cmp_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_id_q    <= '0;
            rsp_equal_q <= 1'b0;
            rsp_z_q     <= 1'b0;
            cmp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_equal_q <= rsp_equal_d;
            rsp_z_q     <= rsp_z_d;
            cmp_count_q <= cmp_count_d;
        end
    end

    // The state register already reads IDLE during reset, but requests could
    // still look grantable combinationally; gate ready so reset holds it low.
    assign req_ready = rst ? '0 : ready_c;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_equal = rsp_equal_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = 1'b0;
    assign cmp_count = cmp_count_q;

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// tb_eq_compare_arbiter
//
// Bench for eq_compare_arbiter: a 4-requester 32-bit instance for the main
// function and a 3-requester 8-bit instance for pointer wrap and counter wrap.

module tb_eq_compare_arbiter;

    logic         clk = 1'b0;
    logic         rst;

    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic         rsp_equal;
    logic         rsp_z;
    logic         rsp_n;
    logic         busy;
    logic [15:0]  cmp_count;

    logic [2:0]   v3;
    logic [2:0]   ready3;
    logic [23:0]  a3;
    logic [23:0]  b3;
    logic         rsp_valid3;
    logic         rr3;
    logic [1:0]   rsp_id3;
    logic         eq3;
    logic         z3;
    logic         n3;
    logic         busy3;
    logic [15:0]  count3;

    int           checks   = 0;
    int           failures = 0;
    int           mdlPtr;
    logic [15:0]  mdlCount;
    logic [15:0]  mdl3Count;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] b;
        int          expId;
        logic        expEq;
    } vec_t;

    vec_t vecs[8];

    eq_compare_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_equal (rsp_equal),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    eq_compare_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v3),
        .req_ready (ready3),
        .req_a     (a3),
        .req_b     (b3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rr3),
        .rsp_id    (rsp_id3),
        .rsp_equal (eq3),
        .rsp_z     (z3),
        .rsp_n     (n3),
        .busy      (busy3),
        .cmp_count (count3)
    );

    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Round-robin reference: first set bit of mask starting at p, wrapping.
    function automatic int modelPick(input logic [3:0] mask, input int p);
        for (int k = 0; k < 4; k++) begin
            if (mask[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Drives one transaction on the 4-requester instance, starting one step
    // after a rising edge with the arbiter idle. The response is held back for
    // 'stall' cycles before rsp_ready is raised.
    task automatic applyStimulus(input logic [3:0] mask, input logic [127:0] a,
                                 input logic [127:0] b, input int stall, input int expId);
        logic [3:0]  oh;
        logic [3:0]  rest;
        logic        expEq;
        oh    = 4'b0001 << expId;
        rest  = mask & ~oh;
        expEq = (a[expId*32 +: 32] == b[expId*32 +: 32]);

        req_valid = mask;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        #1;
        checkOutput("grant", req_ready, oh);

        @(posedge clk); #1;
        req_valid = rest;
        req_a[expId*32 +: 32] = $urandom;
        req_b[expId*32 +: 32] = $urandom;
        #1;
        checkOutput("cmp_rsp_valid", rsp_valid, 0);
        checkOutput("cmp_busy", busy, 1);
        checkOutput("cmp_ready", req_ready, 0);

        @(posedge clk); #1;
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_id", rsp_id, expId);
        checkOutput("rsp_equal", rsp_equal, expEq);
        checkOutput("rsp_z", rsp_z, !expEq);
        checkOutput("rsp_n", rsp_n, 0);
        checkOutput("resp_ready", req_ready, 0);

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", rsp_valid, 1);
            checkOutput("stall_id", rsp_id, expId);
            checkOutput("stall_equal", rsp_equal, expEq);
            checkOutput("stall_busy", busy, 1);
            checkOutput("stall_ready", req_ready, 0);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mdlCount  = mdlCount + 16'd1;
        mdlPtr    = (expId + 1) % 4;
        #1;
        checkOutput("done_valid", rsp_valid, 0);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_count", cmp_count, mdlCount);
        if (rest != 4'b0000) begin
            checkOutput("pending_grant", req_ready, 4'b0001 << modelPick(rest, mdlPtr));
        end
        req_valid = 4'b0000;
    endtask

    // Single transaction on the 3-requester instance with rsp_ready held high.
    task automatic run3(input logic [2:0] mask, input int expId, input logic wantEq);
        logic [7:0] va;
        va = 8'($urandom);
        a3 = 24'($urandom);
        b3 = 24'($urandom);
        a3[expId*8 +: 8] = va;
        b3[expId*8 +: 8] = wantEq ? va : ~va;
        v3  = mask;
        rr3 = 1'b1;
        #1;
        checkOutput("n3_grant", ready3, 3'b001 << expId);
        @(posedge clk); #1;
        v3 = 3'b000;
        @(posedge clk); #1;
        checkOutput("n3_rsp_valid", rsp_valid3, 1);
        checkOutput("n3_rsp_id", rsp_id3, expId);
        checkOutput("n3_equal", eq3, wantEq);
        checkOutput("n3_z", z3, !wantEq);
        checkOutput("n3_n", n3, 0);
        @(posedge clk); #1;
        mdl3Count = mdl3Count + 16'd1;
        checkOutput("n3_done_valid", rsp_valid3, 0);
        checkOutput("n3_count", count3, mdl3Count);
    endtask

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        logic [3:0]   m;
        int           expG;
        int           nG;
        int           lastCyc;
        int           cyc;

        vecs[0] = '{4'b1111, 32'h0000_0000, 32'h0000_0000, 0, 1'b1};
        vecs[1] = '{4'b0100, 32'h0000_0001, 32'h0000_0001, 2, 1'b1};
        vecs[2] = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0};
        vecs[3] = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1};
        vecs[4] = '{4'b1111, 32'h1234_5678, 32'h1234_5678, 1, 1'b1};
        vecs[5] = '{4'b1001, 32'h0000_0005, 32'h0000_0006, 3, 1'b0};
        vecs[6] = '{4'b1010, 32'h8000_0000, 32'h8000_0000, 1, 1'b1};
        vecs[7] = '{4'b0011, 32'h0000_0000, 32'h0000_0001, 0, 1'b0};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        v3        = 3'b111;
        a3        = '0;
        b3        = '0;
        rr3       = 1'b0;
        mdlPtr    = 0;
        mdlCount  = '0;
        mdl3Count = '0;

        // Reset values, with requests asserted to show ready stays low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_id", rsp_id, 0);
        checkOutput("reset_equal", rsp_equal, 0);
        checkOutput("reset_z", rsp_z, 0);
        checkOutput("reset_n", rsp_n, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", cmp_count, 0);
        checkOutput("reset_ready3", ready3, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0000;
        v3        = 3'b000;
        @(posedge clk); #1;

        // Fairness: all requesters valid, consumer always ready.
        $display("[TB] round-robin fairness");
        req_valid = 4'b1111;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = req_a;
        rsp_ready = 1'b1;
        expG      = mdlPtr;
        nG        = 0;
        lastCyc   = -1;
        cyc       = 0;
        while (nG < 6 && cyc < 40) begin
            #1;
            if (req_ready != 4'b0000) begin
                checkOutput("rr_grant", req_ready, 4'b0001 << expG);
                if (lastCyc >= 0) checkOutput("rr_spacing", cyc - lastCyc, 3);
                lastCyc  = cyc;
                nG++;
                expG     = (expG + 1) % 4;
                mdlCount = mdlCount + 16'd1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (nG < 6) checkOutput("rr_timeout", nG, 6);
        req_valid = 4'b0000;
        mdlPtr    = expG;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("rr_count", cmp_count, mdlCount);
        checkOutput("rr_idle", busy, 0);

        // Asynchronous reset while a response is pending drops it.
        $display("[TB] reset during RESP");
        req_valid = 4'b0001;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = req_a;
        #1;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        checkOutput("pre_reset_valid", rsp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rsp_valid", rsp_valid, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_equal", rsp_equal, 0);
        checkOutput("async_id", rsp_id, 0);
        checkOutput("async_count", cmp_count, 0);
        @(negedge clk);
        rst      = 1'b0;
        mdlPtr   = 0;
        mdlCount = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("dropped_rsp", rsp_valid, 0);
        end

        // Directed vectors; the first one confirms the pointer restarted at 0.
        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = ~ra;
            ra[vecs[i].expId*32 +: 32] = vecs[i].a;
            rb[vecs[i].expId*32 +: 32] = vecs[i].b;
            checkOutput("vec_model_eq", (vecs[i].a == vecs[i].b), vecs[i].expEq);
            applyStimulus(vecs[i].mask, ra, rb, i % 2, vecs[i].expId);
        end

        // Backpressure with a request waiting behind the active one.
        $display("[TB] backpressure");
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = ra;
        expG = modelPick(4'b1010, mdlPtr);
        applyStimulus(4'b1010, ra, rb, 5, expG);

        // Randomised traffic against the round-robin model.
        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            m  = 4'($urandom_range(1, 15));
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 1) == 1) rb[j*32 +: 32] = ra[j*32 +: 32];
            end
            expG = modelPick(m, mdlPtr);
            applyStimulus(m, ra, rb, $urandom_range(0, 3), expG);
        end

        // Three-requester build: pointer wrap and counter wrap.
        $display("[TB] NUM_REQ=3 wrap cases");
        run3(3'b100, 2, 1'b1);
        run3(3'b111, 0, 1'b0);
        force dut3.cmp_count_q = 16'hFFFE;
        #1;
        release dut3.cmp_count_q;
        mdl3Count = 16'hFFFE;
        @(posedge clk); #1;
        checkOutput("n3_preload", count3, mdl3Count);
        run3(3'b010, 1, 1'b1);
        checkOutput("n3_count_ffff", count3, 16'hFFFF);
        run3(3'b001, 0, 1'b0);
        checkOutput("n3_count_wrap", count3, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
